cursor_display: RTL and testbench

- Reads the 3-bit cursor position produced by the button/cursor logic: bit2 = row 0..1, bits1:0 = column 0..3, 8 cells total.
- Keeps an 8-cell mark map. A select press toggles the mark under the cursor.
- Drives an 8-digit multiplexed 7-segment display showing marks, with a blinking cursor overlay.
- Sits between the cursor logic and the board display pins.

---
 rtl/cursor_display.sv | 128 ++++++++++++
 tb/tb_cursor_display.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_display.sv
// Cursor/mark display driver: synchronises the select button, keeps an 8-cell mark map and
// scans it onto an 8-digit 7-segment display. Build with CURSOR_BLINK_EN for a blinking cursor.
module cursor_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch,
    input  logic [2:0] pos,
    input  logic       select_n,
    output logic [7:0] seg,
    output logic [7:0] an,
    output logic [7:0] marks,
    output logic [3:0] mark_count
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              s1, s2, p;
    logic              press_q, press_d;
    logic [7:0]        marks_q, marks_d;
    logic [3:0]        count_q, count_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        seg_q, seg_d;
    logic [7:0]        an_q, an_d;
    logic              blink;
    logic              cursor_here;

`ifdef CURSOR_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV != 0);
    assign blink = 1'b1;
`endif

    always_comb begin
        // One-cycle pulse on the falling edge of the synchronised button
        press_d = p & ~s2;

        marks_d = marks_q;
        if (press_q && switch) begin
            marks_d[pos] = ~marks_q[pos];
        end

        count_d = '0;
        for (int i = 0; i < 8; i++) begin
            count_d = count_d + {3'b000, marks_q[i]};
        end

        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end

        an_d        = ~(8'd1 << idx_q);
        cursor_here = (idx_q == pos) && blink;
        unique case ({cursor_here, marks_q[idx_q]})
            2'b00:   seg_d = 8'hFF;
            2'b01:   seg_d = 8'hC0;
            2'b10:   seg_d = 8'hBF;
            2'b11:   seg_d = 8'h40;
            default: seg_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            p          <= 1'b1;
            press_q    <= 1'b0;
            marks_q    <= '0;
            count_q    <= '0;
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= 8'hFF;
            an_q       <= 8'hFF;
        end else begin
            s1         <= select_n;
            s2         <= s1;
            p          <= s2;
            press_q    <= press_d;
            marks_q    <= marks_d;
            count_q    <= count_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign marks      = marks_q;
    assign mark_count = count_q;

endmodule

// File: tb/tb_cursor_display.sv
// Directed bench for cursor_display: two instances share stimulus, one scanning every 2 cycles
// and one every 3 so the blink phase drifts across digits.
module tb_cursor_display;

    logic       clk = 1'b0;
    logic       reset;
    logic       switch;
    logic [2:0] pos;
    logic       select_n;
    logic [7:0] seg_a, an_a, marks_a;
    logic [3:0] mc_a;
    logic [7:0] seg_b, an_b, marks_b;
    logic [3:0] mc_b;

    int errors = 0;
    int checks = 0;
    int k = 0;

    always #5 clk = ~clk;

    cursor_display #(.SCAN_DIV(2), .BLINK_DIV(8)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .pos        (pos),
        .select_n   (select_n),
        .seg        (seg_a),
        .an         (an_a),
        .marks      (marks_a),
        .mark_count (mc_a)
    );

    cursor_display #(.SCAN_DIV(3), .BLINK_DIV(8)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .pos        (pos),
        .select_n   (select_n),
        .seg        (seg_b),
        .an         (an_b),
        .marks      (marks_b),
        .mark_count (mc_b)
    );

    // k = clock edges seen with reset low since the last reset edge
    task automatic tick();
        @(posedge clk);
        if (reset) k = 0;
        else k = k + 1;
        #1;
    endtask

    function automatic logic [7:0] exp_an(input int kk, input int s);
        int idx;
        idx = ((kk - 1) / s) % 8;
        return ~(8'd1 << idx);
    endfunction

    function automatic logic [7:0] exp_seg(input int kk, input int s, input int b,
                                           input logic [7:0] m, input logic [2:0] cp);
        int   idx;
        logic ph;
        logic cur;
        idx = ((kk - 1) / s) % 8;
`ifdef CURSOR_BLINK_EN
        ph = ((((kk - 1) / b) % 2) == 0);
`else
        ph = (b > 0);
`endif
        cur = (idx == int'(cp)) && ph;
        if (cur && m[idx]) return 8'h40;
        if (cur) return 8'hBF;
        if (m[idx]) return 8'hC0;
        return 8'hFF;
    endfunction

    task automatic do_press(input logic [2:0] cp);
        pos = cp;
        select_n = 1'b0;
        repeat (6) tick();
        select_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        switch = 1'b0;
        pos = 3'd0;
        select_n = 1'b1;
        tick();
        tick();
        checks++; if (an_a !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", an_a); end
        checks++; if (seg_a !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", seg_a); end
        checks++; if (marks_a !== 8'h00) begin errors++; $display("FAIL reset_marks: got %h expected 00", marks_a); end
        checks++; if (mc_a !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", mc_a); end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        logic [7:0] ea, es;
        pos = 3'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            ea = exp_an(k, 2);
            es = exp_seg(k, 2, 8, 8'h00, pos);
            checks++; if (an_a !== ea) begin errors++; $display("FAIL scan_an k=%0d: got %h expected %h", k, an_a, ea); end
            checks++; if (seg_a !== es) begin errors++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg_a, es); end
        end
    endtask

    task automatic test_press();
        logic [7:0] ea, es;
        switch = 1'b1;
        pos = 3'd5;
        select_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (marks_a !== 8'h00) begin errors++; $display("FAIL press_early e%0d: got %h expected 00", i, marks_a); end
        end
        tick();
        checks++; if (marks_a !== 8'h20) begin errors++; $display("FAIL press_toggle: got %h expected 20", marks_a); end
        checks++; if (mc_a !== 4'd0) begin errors++; $display("FAIL press_count_lag: got %0d expected 0", mc_a); end
        tick();
        checks++; if (mc_a !== 4'd1) begin errors++; $display("FAIL press_count: got %0d expected 1", mc_a); end
        for (int i = 0; i < 15; i++) begin
            if (i == 5) select_n = 1'b1;
            tick();
            checks++; if (marks_a !== 8'h20) begin errors++; $display("FAIL press_hold i=%0d: got %h expected 20", i, marks_a); end
        end
        for (int i = 0; i < 48; i++) begin
            tick();
            ea = exp_an(k, 2);
            es = exp_seg(k, 2, 8, 8'h20, pos);
            checks++; if (an_a !== ea || seg_a !== es) begin
                errors++; $display("FAIL press_disp_a k=%0d: got %h/%h expected %h/%h", k, an_a, seg_a, ea, es);
            end
            ea = exp_an(k, 3);
            es = exp_seg(k, 3, 8, 8'h20, pos);
            checks++; if (an_b !== ea || seg_b !== es) begin
                errors++; $display("FAIL press_disp_b k=%0d: got %h/%h expected %h/%h", k, an_b, seg_b, ea, es);
            end
        end
    endtask

    task automatic test_switch_off();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        switch = 1'b0;
        pos = 3'd2;
        select_n = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 5) switch = 1'b1;
            if (i == 10) select_n = 1'b1;
            tick();
            checks++; if (marks_a !== 8'h00 || mc_a !== 4'd0) begin
                errors++; $display("FAIL switch_off i=%0d: got %h/%0d expected 00/0", i, marks_a, mc_a);
            end
        end
    endtask

    task automatic test_toggle();
        logic [7:0] em;
        switch = 1'b1;
        do_press(3'd3);
        checks++; if (marks_a !== 8'h08) begin errors++; $display("FAIL toggle_on: got %h expected 08", marks_a); end
        do_press(3'd3);
        checks++; if (marks_a !== 8'h00) begin errors++; $display("FAIL toggle_off: got %h expected 00", marks_a); end
        em = 8'h00;
        for (int i = 0; i < 8; i++) begin
            do_press(3'(i));
            em = em | (8'd1 << i);
            checks++; if (marks_a !== em) begin errors++; $display("FAIL toggle_all p=%0d: got %h expected %h", i, marks_a, em); end
        end
        checks++; if (mc_a !== 4'd8) begin errors++; $display("FAIL toggle_count: got %0d expected 8", mc_a); end
    endtask

    task automatic test_reset_midscan();
        logic [7:0] es;
        for (int i = 0; i < 20 && ((k / 2) % 8) != 4; i++) tick();
        checks++; if (marks_a !== 8'hFF) begin errors++; $display("FAIL midscan_pre: got %h expected ff", marks_a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (marks_a !== 8'h00 || mc_a !== 4'd0) begin
            errors++; $display("FAIL midscan_marks: got %h/%0d expected 00/0", marks_a, mc_a);
        end
        checks++; if (an_a !== 8'hFF || seg_a !== 8'hFF) begin
            errors++; $display("FAIL midscan_disp: got %h/%h expected ff/ff", an_a, seg_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            es = exp_seg(k, 2, 8, 8'h00, pos);
            checks++; if (an_a !== exp_an(k, 2) || seg_a !== es) begin
                errors++; $display("FAIL midscan_restart k=%0d: got %h/%h expected %h/%h", k, an_a, seg_a, exp_an(k, 2), es);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] es;
        int saw_bf = 0;
        int saw_ff = 0;
        pos = 3'd7;
        for (int i = 0; i < 96; i++) begin
            tick();
            es = exp_seg(k, 3, 8, 8'h00, pos);
            checks++; if (an_b !== exp_an(k, 3) || seg_b !== es) begin
                errors++; $display("FAIL blink_b k=%0d: got %h/%h expected %h/%h", k, an_b, seg_b, exp_an(k, 3), es);
            end
            if (an_b == 8'h7F && seg_b == 8'hBF) saw_bf++;
            if (an_b == 8'h7F && seg_b == 8'hFF) saw_ff++;
        end
`ifdef CURSOR_BLINK_EN
        checks++; if (saw_bf == 0 || saw_ff == 0) begin
            errors++; $display("FAIL blink_alternate: got bf=%0d ff=%0d expected both nonzero", saw_bf, saw_ff);
        end
`else
        checks++; if (saw_bf == 0 || saw_ff != 0) begin
            errors++; $display("FAIL blink_steady: got bf=%0d ff=%0d expected bf>0 ff=0", saw_bf, saw_ff);
        end
`endif
    endtask

    task automatic test_pos_change();
        switch = 1'b1;
        pos = 3'd1;
        select_n = 1'b0;
        repeat (3) tick();
        pos = 3'd6;
        tick();
        checks++; if (marks_a !== 8'h40) begin errors++; $display("FAIL pos_change: got %h expected 40", marks_a); end
        select_n = 1'b1;
        repeat (6) tick();
        checks++; if (marks_a !== 8'h40 || mc_a !== 4'd1) begin
            errors++; $display("FAIL pos_change_settle: got %h/%0d expected 40/1", marks_a, mc_a);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_press();
        test_switch_off();
        test_toggle();
        test_reset_midscan();
        test_blink();
        test_pos_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
